spi_controller: RTL and testbench

SPI write initiator: the controller end of the 16-bit register-write link that the chip's `spi_peripheral` decodes. It accepts register-write requests on a valid/ready handshake and serialises each one as one SPI mode-0 frame (CPOL=0, CPHA=0), MSB first, on `ncs`/`sclk`/`copi`. It sits in test-harness and companion-chip logic that programs the output-enable, PWM-enable and duty-cycle registers.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_controller.sv | 156 +++++++++++++++
 tb/tb_spi_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write link: frame layout, register map
// and the controller state encoding.
package spi_pkg;

    localparam int FRAME_BITS     = 16;
    localparam int WRITE_FLAG_BIT = 15;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] addr,
                                                          input logic [7:0] data);
        logic [FRAME_BITS-1:0] f;
        f                 = '0;
        f[WRITE_FLAG_BIT] = 1'b1;
        f[14:8]           = addr;
        f[7:0]            = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: asserts tick once every HALF_PERIOD enabled cycles,
// realigned to a fresh full period by restart.
module spi_clk_div #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

    logic [7:0] cnt_q;

    assign tick = en && (cnt_q == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else if (restart || tick) begin
            cnt_q <= RELOAD;
        end else if (en) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: accepts one register write per handshake and sends it
// as a 16-bit MSB-first frame framed by ncs.
//
// state | meaning
// IDLE  | ready for a request, ncs high, sclk low
// SETUP | ncs low, first bit on copi, waiting one half-period before the first rise
// SHIFT | sclk toggling every half-period, 16 bits clocked out
// HOLD  | sclk low, ncs still low for one half-period after the last fall
// GAP   | ncs high for GAP_CYCLES before the next request may be accepted
module spi_controller
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);

    spi_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic                  tail_q, tail_d;
    logic                  sclk_q, sclk_d;
    logic                  ncs_q, ncs_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  div_en, div_restart, tick;

    spi_clk_div #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (div_en),
        .restart(div_restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            tail_q    <= 1'b0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tail_q    <= tail_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tail_d      = tail_q;
        sclk_d      = sclk_q;
        ncs_d       = ncs_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        div_en      = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
        div_restart = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d     = ST_SETUP;
                    shift_d     = build_frame(req_addr, req_data);
                    bit_cnt_d   = '0;
                    tail_d      = 1'b0;
                    ncs_d       = 1'b0;
                    sclk_d      = 1'b0;
                    ready_d     = 1'b0;
                    div_restart = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d   = ST_SHIFT;
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else if (bit_cnt_q != 5'(FRAME_BITS)) begin
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end else if (!tail_q) begin
                        // last bit: sclk held high for one extra half-period
                        tail_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_GAP;
                    ncs_d     = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = 8'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ncs_d   = 1'b1;
                sclk_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign sclk      = sclk_q;
    assign copi      = shift_q[FRAME_BITS-1];
    assign ncs       = ncs_q;
    assign req_ready = ready_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a driver queues expected frames, a pin-level
// monitor decodes the SPI bus, checks frame timing and compares against the queue.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int H = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, sclk, copi, ncs, busy, done;

    spi_controller #(
        .HALF_PERIOD(H),
        .GAP_CYCLES (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .sclk     (sclk),
        .copi     (copi),
        .ncs      (ncs),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          tests = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  dec_regs[5];
    int          frames_done = 0;
    int          dones_seen = 0;
    int          mon_rises = 0;
    bit          mon_in_frame = 0;
    int          last_acc = 0;
    bit          last_keep = 0;
    int          n_accepted = 0;
    int          n_aborted = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $fatal(1, "aborted");
    endtask

    // Pin-level monitor: decodes frames and checks every timing relation against H/G.
    initial begin : monitor
        logic        p_ncs, p_sclk, p_copi, p_ready;
        logic [15:0] rx, expf;
        int          t0, t_end;
        bit          gap_armed, was_in;
        bit          ncs_fell, ncs_rose, sclk_rose, sclk_fell;
        p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0; p_ready = 1'b1;
        rx = '0; t0 = 0; t_end = 0; gap_armed = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                chk("rst_ncs", int'(ncs), 1);
                chk("rst_sclk", int'(sclk), 0);
                chk("rst_copi", int'(copi), 0);
                chk("rst_ready", int'(req_ready), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                mon_in_frame = 0;
                gap_armed = 0;
                mon_rises = 0;
                foreach (dec_regs[i]) dec_regs[i] = 8'h00;
            end else begin
                ncs_fell  = p_ncs && !ncs;
                ncs_rose  = !p_ncs && ncs;
                sclk_rose = !p_sclk && sclk;
                sclk_fell = p_sclk && !sclk;
                was_in    = mon_in_frame;
                chk("ready_vs_busy", int'(req_ready), int'(!busy));
                if (done) begin
                    dones_seen++;
                    chk("done_only_at_frame_end", int'(was_in && ncs_rose), 1);
                end
                if (ncs_fell) begin
                    mon_in_frame = 1;
                    t0 = cyc;
                    mon_rises = 0;
                    rx = '0;
                    chk("sclk_low_at_ncs_fall", int'(sclk), 0);
                end else if (mon_in_frame) begin
                    chk("copi_stable", int'((copi !== p_copi) && !sclk_fell), 0);
                    if (sclk_rose) begin
                        mon_rises++;
                        rx = {rx[14:0], copi};
                        chk("rise_time", cyc - t0, (2 * mon_rises - 1) * H);
                    end
                    if (sclk_fell && mon_rises == 16)
                        chk("last_fall_time", cyc - t0, 33 * H);
                    if (ncs_rose) begin
                        chk("ncs_low_len", cyc - t0, 34 * H);
                        chk("rise_count", mon_rises, 16);
                        chk("done_pulse", int'(done), 1);
                        chk("sclk_low_at_ncs_rise", int'(sclk), 0);
                        if (exp_q.size() == 0) begin
                            tests++;
                            errors++;
                            $display("FAIL frame_unexpected: got %04h expected none", rx);
                        end else begin
                            expf = exp_q.pop_front();
                            chk("frame", int'(rx), int'(expf));
                        end
                        if (rx[15] && rx[14:8] <= 7'd4) dec_regs[int'(rx[14:8])] = rx[7:0];
                        frames_done++;
                        mon_in_frame = 0;
                        t_end = cyc;
                        gap_armed = 1;
                    end
                end else begin
                    chk("sclk_idle_low", int'(sclk), 0);
                end
                if (!p_ready && req_ready && gap_armed) begin
                    chk("gap_len", cyc - t_end, G);
                    gap_armed = 0;
                end
            end
            p_ncs = ncs; p_sclk = sclk; p_copi = copi; p_ready = req_ready;
        end
    end

    task automatic send(input logic [6:0] a, input logic [7:0] d, input int idle, input bit keep);
        int n;
        if (idle > 0) begin
            req_valid = 1'b0;
            repeat (idle) @(negedge clk);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        n = 0;
        while (req_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 4000) begin
                tests++;
                errors++;
                $display("FAIL ready_timeout: got ready=%0b expected 1 within 4000 cycles", req_ready);
                finish_now();
            end
        end
        @(posedge clk);
        exp_q.push_back({1'b1, a, d});
        n_accepted++;
        @(negedge clk);
        if (last_keep) chk("b2b_spacing", cyc - last_acc, 34 * H + G + 1);
        last_acc  = cyc;
        last_keep = keep;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000);
        chk("idle_reached", (n < 5000) ? 1 : 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        tests++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        finish_now();
    end

    initial begin : stimulus
        int          bad, n, idle;
        bit          keep;
        logic [6:0]  ra;
        logic [7:0]  rd;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ncs !== 1'b1 || sclk !== 1'b0 || copi !== 1'b0 || req_ready !== 1'b1 ||
                busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_100_cycles", bad, 0);

        // single write, then back-to-back with valid held
        send(ADDR_PWM_DUTY, 8'hA5, 1, 0);
        wait_idle();
        send(ADDR_EN_OUT_7_0, 8'hFF, 2, 1);
        send(ADDR_EN_OUT_15_8, 8'h0F, 0, 0);
        wait_idle();

        // inputs changed (and valid kept high) while a frame is in flight
        send(ADDR_EN_PWM_7_0, 8'h3C, 2, 0);
        req_valid = 1'b1;
        req_addr  = 7'h7F;
        req_data  = 8'h00;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen_while_valid_held", int'(done), 1);
        req_valid = 1'b0;
        wait_idle();

        // reset after the 5th rising sclk
        send(7'h01, 8'h11, 2, 0);
        n = 0;
        while (!(mon_in_frame && mon_rises == 5) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_5th_rise", mon_rises, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ncs", int'(ncs), 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        exp_q.delete();
        n_aborted++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(ADDR_EN_PWM_15_8, 8'h81, 2, 0);
        wait_idle();

        // randomized traffic, including held-valid back-to-back runs
        for (int i = 0; i < 25; i++) begin
            ra   = 7'($urandom_range(0, 127));
            rd   = 8'($urandom_range(0, 255));
            keep = (i != 24) && ($urandom_range(0, 3) == 0);
            idle = last_keep ? 0 : $urandom_range(1, 4);
            send(ra, rd, idle, keep);
        end
        wait_idle();

        // loopback register effect, from a freshly reset register file
        pulse_reset();
        send(ADDR_EN_OUT_7_0, 8'h12, 2, 0);
        send(ADDR_PWM_DUTY, 8'h80, 2, 0);
        send(7'h05, 8'h55, 2, 0);
        wait_idle();
        chk("reg_en_out_7_0", int'(dec_regs[0]), 'h12);
        chk("reg_en_out_15_8", int'(dec_regs[1]), 'h00);
        chk("reg_en_pwm_7_0", int'(dec_regs[2]), 'h00);
        chk("reg_en_pwm_15_8", int'(dec_regs[3]), 'h00);
        chk("reg_pwm_duty", int'(dec_regs[4]), 'h80);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("frames_completed", frames_done, n_accepted - n_aborted);
        chk("done_count", dones_seen, frames_done);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
